// File: rtl/apb2axi_rd_word_buf.sv
// Per-tag AXI read-beat buffer that serves completed bursts to APB one word at a time.
// Optional tag flush port set enabled by defining APB2AXI_RDBUF_FLUSH_EN.
module apb2axi_rd_word_buf #(
   parameter int  AXI_DATA_W = 64,
   parameter int  APB_DATA_W = 32,
   parameter int  TAG_NUM    = 16,
   parameter int  MAX_BEATS  = 16,
   localparam int TAG_W      = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1,
   localparam int BEAT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef APB2AXI_RDBUF_FLUSH_EN
   input  logic                  flush,
   input  logic [TAG_W-1:0]      flush_tag,
`endif
   input  logic                  rdf_valid,
   output logic                  rdf_ready,
   input  logic [TAG_W-1:0]      rdf_tag,
   input  logic [AXI_DATA_W-1:0] rdf_data,
   input  logic [1:0]            rdf_resp,
   input  logic                  rdf_last,
   input  logic                  rd_req,
   input  logic [TAG_W-1:0]      rd_tag,
   output logic                  rd_valid,
   output logic [APB_DATA_W-1:0] rd_data,
   output logic                  rd_err,
   output logic [TAG_NUM-1:0]    tag_done,
   output logic [TAG_NUM-1:0]    tag_err,
   output logic                  tag_free,
   output logic [TAG_W-1:0]      tag_free_id
);

   // state      | meaning
   // ST_EMPTY   | no beats held, tag idle
   // ST_FILLING | at least one beat accepted, last beat not yet seen
   // ST_DONE    | last beat accepted, draining words to APB

   localparam int RATIO  = AXI_DATA_W / APB_DATA_W;
   localparam int WORD_W = $clog2(MAX_BEATS * RATIO + 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_DONE} tag_state_e;

   tag_state_e            state_q   [TAG_NUM];
   logic [BEAT_W:0]       wr_beat_q [TAG_NUM];
   logic [WORD_W-1:0]     rd_word_q [TAG_NUM];
   logic [TAG_NUM-1:0]    err_q;
   logic [AXI_DATA_W-1:0] mem       [TAG_NUM][MAX_BEATS];

   logic                  flush_any;
   logic [TAG_W-1:0]      flush_id;
   logic                  flush_rd;
   logic                  beat_fire;
   logic                  beat_room;
   logic [WORD_W-1:0]     rd_word_cur;
   logic [WORD_W-1:0]     rd_total;
   logic                  rd_last_word;
   logic                  rd_hit;
   logic [BEAT_W-1:0]     rd_beat_idx;
   logic [AXI_DATA_W-1:0] rd_beat;
   logic [APB_DATA_W-1:0] rd_word_data;

`ifdef APB2AXI_RDBUF_FLUSH_EN
   assign flush_any = flush;
   assign flush_id  = flush_tag;
`else
   assign flush_any = 1'b0;
   assign flush_id  = '0;
`endif

   always_comb begin
      tag_done = '0;
      for (int i = 0; i < TAG_NUM; i++)
         tag_done[i] = (state_q[i] == ST_DONE);
   end

   assign tag_err   = err_q;
   assign rdf_ready = !tag_done[rdf_tag];
   assign beat_fire = rdf_valid && rdf_ready;
   // wr_beat saturates at MAX_BEATS, so it doubles as the stored beat count
   assign beat_room = wr_beat_q[rdf_tag] < (BEAT_W+1)'(MAX_BEATS);

   assign flush_rd     = flush_any && (flush_id == rd_tag);
   assign rd_word_cur  = rd_word_q[rd_tag];
   assign rd_total     = WORD_W'(wr_beat_q[rd_tag]) * WORD_W'(RATIO);
   assign rd_last_word = (rd_word_cur == rd_total - WORD_W'(1));
   assign rd_hit       = rd_req && (state_q[rd_tag] == ST_DONE) && !flush_rd;
   assign rd_beat_idx  = BEAT_W'(rd_word_cur / WORD_W'(RATIO));
   assign rd_beat      = mem[rd_tag][rd_beat_idx];
   assign rd_word_data = APB_DATA_W'(rd_beat >> (APB_DATA_W * int'(rd_word_cur % WORD_W'(RATIO))));

   always_ff @(posedge clk) begin
      if (beat_fire && beat_room)
         mem[rdf_tag][wr_beat_q[rdf_tag][BEAT_W-1:0]] <= rdf_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAG_NUM; i++) begin
            state_q[i]   <= ST_EMPTY;
            wr_beat_q[i] <= '0;
            rd_word_q[i] <= '0;
         end
         err_q       <= '0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_err      <= 1'b0;
         tag_free    <= 1'b0;
         tag_free_id <= '0;
      end else begin
         rd_valid <= rd_req;
         tag_free <= 1'b0;

         if (beat_fire) begin
            state_q[rdf_tag] <= rdf_last ? ST_DONE : ST_FILLING;
            if (beat_room)
               wr_beat_q[rdf_tag] <= wr_beat_q[rdf_tag] + (BEAT_W+1)'(1);
            if (!beat_room || (rdf_resp != 2'b00))
               err_q[rdf_tag] <= 1'b1;
         end

         if (rd_req) begin
            if (rd_hit) begin
               rd_data <= rd_word_data;
               rd_err  <= err_q[rd_tag];
               if (rd_last_word) begin
                  state_q[rd_tag]   <= ST_EMPTY;
                  wr_beat_q[rd_tag] <= '0;
                  rd_word_q[rd_tag] <= '0;
                  err_q[rd_tag]     <= 1'b0;
                  tag_free          <= 1'b1;
                  tag_free_id       <= rd_tag;
               end else begin
                  rd_word_q[rd_tag] <= rd_word_cur + WORD_W'(1);
               end
            end else begin
               rd_data <= '0;
               rd_err  <= 1'b1;
            end
         end

         // flush is last so it overrides a same-cycle beat or drain on its tag
         if (flush_any) begin
            state_q[flush_id]   <= ST_EMPTY;
            wr_beat_q[flush_id] <= '0;
            rd_word_q[flush_id] <= '0;
            err_q[flush_id]     <= 1'b0;
            tag_free            <= 1'b1;
            tag_free_id         <= flush_id;
         end
      end
   end

endmodule

// File: doc/apb2axi_rd_word_buf.md
# apb2axi_rd_word_buf

Parametrised per-tag read-data buffer between the AXI read response handler and the APB register file. Captures AXI R beats per tag into dedicated storage, marks a tag complete on the last beat, then serves the burst to APB one APB word at a time in address order. Successor to the single-width read FIFO: generalised in bus-width ratio, tag count and burst depth, with out-of-order tag drain, per-tag sticky error and automatic tag release.

## Interface
- AXI_DATA_W, 64, R beat width; integer multiple of APB_DATA_W.
- APB_DATA_W, 32, APB word width.
- TAG_NUM, 16, number of independent tags; TAG_W = max(1, clog2(TAG_NUM)).
- MAX_BEATS, 16, beat slots per tag; BEAT_W = max(1, clog2(MAX_BEATS)); RATIO = AXI_DATA_W/APB_DATA_W.
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- rdf_valid  in  1  beat offered.
- rdf_ready  out  1  beat accepted when valid&ready.
- rdf_tag  in  TAG_W  beat tag.
- rdf_data  in  AXI_DATA_W  beat data.
- rdf_resp  in  2  AXI RRESP.
- rdf_last  in  1  last beat of burst.
- rd_req  in  1  one-cycle APB word read request.
- rd_tag  in  TAG_W  tag to read.
- rd_valid  out  1  rd_data valid (one cycle).
- rd_data  out  APB_DATA_W  returned word.
- rd_err  out  1  with rd_valid: tag not done, or tag sticky error.
- tag_done  out  TAG_NUM  per-tag complete, awaiting drain.
- tag_err  out  TAG_NUM  per-tag sticky error (any resp≠OKAY or overflow).
- tag_free  out  1  pulse: tag fully drained and released.
- tag_free_id  out  TAG_W  released tag.

## Operation
- Per tag: state EMPTY→FILLING (first beat)→DONE (last beat accepted)→EMPTY (last word read). Registers: wr_beat (BEAT_W+1), rd_word, beat_cnt, err.
- rdf_ready = !tag_done[rdf_tag]. Accepted beat written to slot wr_beat of its tag; wr_beat++.
- Beat when wr_beat==MAX_BEATS: data dropped, err set; rdf_last still completes the tag.
- resp SLVERR/DECERR on any beat sets err; err stays set until release.
- Word order little-endian: word k → beat k/RATIO, bits [(k%RATIO)*APB_DATA_W +: APB_DATA_W]. Total words = beat_cnt*RATIO (beat_cnt capped at MAX_BEATS).
- rd_req on DONE tag: return word rd_word, rd_err=err, rd_word++. Final word: tag→EMPTY, counters and err cleared, tag_done/tag_err bits clear, tag_free pulse with id.
- rd_req on non-DONE tag: rd_data=0, rd_err=1, no state change.
- Tags drained in any order; reads of different tags interleave freely.
- Same-cycle beat push and word read touch different tags by construction (push blocked on DONE tags); both proceed.

## Timing
- Reset: rdf_ready=1, rd_valid=0, rd_data=0, rd_err=0, tag_done=0, tag_err=0, tag_free=0, tag_free_id=0; all tags EMPTY. Reset mid-burst discards all stored data.
- Beat accept → storage write at that edge; tag_done/tag_err visible the cycle after the rdf_last beat is accepted.
- rd_req cycle N → rd_valid/rd_data/rd_err registered, valid in N+1. Back-to-back rd_req each cycle supported (one word per cycle).
- Final word read at N → tag_done bit low and tag_free pulse in N+1; tag accepts new beats from N+1.
- rdf_ready combinational from rdf_tag and tag_done only.

## Configuration
- APB2AXI_RDBUF_FLUSH_EN defined: adds inputs flush (1) and flush_tag (TAG_W); flush pulse returns tag to EMPTY next cycle, clears counters/err, pulses tag_free; flush wins over same-cycle beat or read on that tag (read returns rd_err=1, data 0).
- Undefined: ports absent; tags release only by full drain.

## Test plan
- Tag 3, 2 beats 0x1111_2222_3333_4444, 0x5555_6666_7777_8888 OKAY → tag_done[3]=1; 4 reads return 0x33334444, 0x11112222, 0x77778888, 0x55556666, rd_err=0; tag_free pulse id=3 after 4th.
- Interleaved beats tags 1 and 2, tag 2 last first → tag_done=0x0004 then 0x0006; drain tag 2 before tag 1, data per tag intact.
- Beat 1 of tag 5 with resp=2'b10 → tag_err[5]=1; every word read rd_err=1, data correct; cleared after release.
- 17 beats to tag 0 (MAX_BEATS=16) → 17th dropped, tag_err[0]=1, 32 words readable.
- rd_req on EMPTY tag 7 → rd_valid=1, rd_data=0, rd_err=1; push to DONE tag → rdf_ready=0 until drained.
- Flush (macro on) tag 4 mid-fill → tag_free id=4 next cycle; reset mid-burst → all outputs at reset values.
